wallace_tree_multiplier32: RTL and testbench

- Signed 32x32 -> 64-bit multiplier for the ALU multiplier unit.
- Partial products use the Baugh-Wooley signed scheme and are reduced by a Wallace tree of full/half adders. A final carry-propagate adder closes the tree.
- The combinational result is captured in an output register, giving one cycle of latency.
- Companion to the array and Booth multipliers in the same unit; drop-in wherever a registered signed product is needed.

---
 rtl/wallace_tree_multiplier32.sv | 104 ++++++++++
 tb/tb_wallace_tree_multiplier32.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wallace_tree_multiplier32.sv
// Signed 32x32 -> 64-bit multiplier with a one-cycle registered output.
// Partial products use the Baugh-Wooley signed form; rows are reduced by a
// Wallace tree of carry-save adders to two rows, which a 64-bit adder sums.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (clears result and out_valid)
//   in_valid  op1/op2 carry a valid operand pair this cycle
//   op1, op2  32-bit two's complement operands
//   out_valid result holds the product of the pair sampled one cycle earlier
//   result    64-bit two's complement product
module wallace_tree_multiplier32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        out_valid,
  output logic [63:0] result
);

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  // 32 partial-product rows plus one row holding the correction constants.
  localparam int unsigned ROWS   = OP_W + 1;
  // 33 -> 22 -> 15 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2 rows.
  localparam int unsigned STAGES = 8;

  // Baugh-Wooley correction: +2^32 and +2^63 (the -2^63 term taken mod 2^64).
  localparam logic [PROD_W-1:0] BW_CONST = 64'h8000_0001_0000_0000;

  logic [PROD_W-1:0] sum_row_c;
  logic [PROD_W-1:0] carry_row_c;
  logic [PROD_W-1:0] product_c;

  // Partial-product generation and Wallace reduction down to two rows.
  always_comb begin : tree
    logic [PROD_W-1:0] cur [ROWS];
    logic [PROD_W-1:0] nxt [ROWS];
    logic              pp_bit;
    int                n;
    int                full;
    int                rem;

    for (int r = 0; r < int'(ROWS); r++) begin
      cur[r] = '0;
      nxt[r] = '0;
    end
    pp_bit = 1'b0;

    // Terms pairing exactly one sign bit with a magnitude bit are inverted.
    for (int i = 0; i < int'(OP_W); i++) begin
      for (int j = 0; j < int'(OP_W); j++) begin
        pp_bit = op1[j] & op2[i];
        if ((i == int'(OP_W) - 1) != (j == int'(OP_W) - 1)) pp_bit = ~pp_bit;
        cur[i][i+j] = pp_bit;
      end
    end
    cur[ROWS-1] = BW_CONST;

    // Each stage compresses every full group of three rows into a sum row
    // and a shifted carry row; leftover rows pass straight through. Bit
    // positions where a row is constant zero collapse to half adders.
    n = int'(ROWS);
    for (int s = 0; s < int'(STAGES); s++) begin
      if (n > 2) begin
        full = n / 3;
        rem  = n % 3;
        for (int r = 0; r < int'(ROWS); r++) nxt[r] = '0;
        for (int g = 0; g < int'(ROWS) / 3; g++) begin
          if (g < full) begin
            nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
            nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) |
                          (cur[3*g] & cur[3*g+2]) |
                          (cur[3*g+1] & cur[3*g+2])) << 1;
          end
        end
        for (int k = 0; k < int'(ROWS); k++) begin
          if (k >= 3 * full && k < n) nxt[k - full] = cur[k];
        end
        for (int r = 0; r < int'(ROWS); r++) cur[r] = nxt[r];
        n = 2 * full + rem;
      end
    end

    sum_row_c   = cur[0];
    carry_row_c = cur[1];
  end

  // Final carry-propagate adder; carry out of bit 63 is dropped.
  assign product_c = sum_row_c + carry_row_c;

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      result    <= product_c;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_wallace_tree_multiplier32.sv
// Scoreboard bench for wallace_tree_multiplier32: the driver pushes one
// expectation per driven cycle, the monitor pops and compares after each edge.
module tb_wallace_tree_multiplier32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic [63:0] result;

  typedef struct packed {
    logic        v;
    logic        zero;
    logic [63:0] prod;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  wallace_tree_multiplier32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    return 64'(sa * sb_);
  endfunction

  task automatic drive(input logic rst, input logic v, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    in_valid = v;
    op1      = a;
    op2      = b;
    e.v    = rst & v;
    e.zero = ~rst;
    e.prod = ref_mul(a, b);
    sb.push_back(e);
  endtask

  // Monitor: one expectation retired per clock edge.
  initial begin
    exp_t        e;
    logic [63:0] want;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== e.v) begin
          failures++;
          $display("FAIL out_valid: got %b want %b at %0t", out_valid, e.v, $time);
        end
        if (e.v || e.zero) begin
          want = e.zero ? 64'h0 : e.prod;
          checks++;
          if (result !== want) begin
            failures++;
            $display("FAIL result: got %h want %h at %0t", result, want, $time);
          end
        end
      end
    end
  end

  logic [31:0] da [19];
  logic [31:0] db [19];

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        v;

    rst_n = 1'b0; in_valid = 1'b1; op1 = 32'd7; op2 = 32'd9;

    da[0]  = 32'd10;        db[0]  = -32'sd5;
    da[1]  = 32'd20;        db[1]  = 32'd15;
    da[2]  = -32'sd5;       db[2]  = -32'sd6;
    da[3]  = -32'sd100;     db[3]  = 32'd25;
    da[4]  = -32'sd123;     db[4]  = 32'd456;
    da[5]  = 32'd1000;      db[5]  = -32'sd25;
    da[6]  = 32'd0;         db[6]  = 32'd50;
    da[7]  = 32'd1;         db[7]  = 32'd100;
    da[8]  = 32'hFFFF_FFFF; db[8]  = 32'hFFFF_FFFF;
    da[9]  = 32'd1;         db[9]  = 32'h8000_0000;
    da[10] = 32'h8000_0000; db[10] = 32'h8000_0000;
    da[11] = 32'h7FFF_FFFF; db[11] = 32'h7FFF_FFFF;
    da[12] = 32'h8000_0000; db[12] = 32'h7FFF_FFFF;
    da[13] = 32'h8000_0000; db[13] = 32'd1;
    da[14] = 32'hDEAD_BEEF; db[14] = 32'd0;
    da[15] = 32'd1;         db[15] = 32'hFFFF_FFFE;
    da[16] = 32'hFFFF_FFFF; db[16] = 32'h8000_0000;
    da[17] = 32'h8000_0001; db[17] = 32'h8000_0001;
    da[18] = 32'hAAAA_AAAA; db[18] = 32'h5555_5555;

    // Reset held two cycles with a valid pair present.
    drive(1'b0, 1'b1, 32'd7, 32'd9);
    drive(1'b0, 1'b1, 32'd7, 32'd9);
    drive(1'b1, 1'b1, 32'd7, 32'd9);

    // Directed sign mixes, identities and extremes, back to back.
    for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, da[i], db[i]);

    // Random streaming with random in_valid and one mid-stream reset.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(7) == 0) a = ($urandom_range(1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if ($urandom_range(7) == 0) b = ($urandom_range(1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      v = 1'($urandom_range(1));
      if (i == 500) drive(1'b0, 1'b1, a, b);
      else          drive(1'b1, v, a, b);
    end

    drive(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish want finish before 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
